sram_rr_scheduler: RTL

Single-clock round-robin scheduler that shares the SRAM port among two write requesters (W0, W1) and two read requesters (R0, R1). It sits on the sram_clock side of the clock-crossing FIFOs. It pops request heads from first-word-fall-through FIFO outputs, issues SRAM commands under a valid/ready handshake, and steers returning read data to the correct read port. Read issue is gated by per-port credits so the downstream read-data FIFOs never overflow.

---
 rtl/sram_rr_scheduler_if.sv | 52 +++++
 rtl/sram_rr_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sram_rr_scheduler_if.sv
// Request FIFO heads, read-return ports and SRAM command bus of the round-robin scheduler.
// The scheduler takes the master modport; its environment (FIFOs and SRAM) takes the slave modport.
interface sram_rr_scheduler_if;
  logic        w0_valid;
  logic [53:0] w0_req;
  logic        w0_pop;
  logic        w1_valid;
  logic [53:0] w1_req;
  logic        w1_pop;
  logic        r0_valid;
  logic [17:0] r0_addr;
  logic        r0_pop;
  logic        r1_valid;
  logic [17:0] r1_addr;
  logic        r1_pop;
  logic        r0_dout_valid;
  logic [31:0] r0_dout;
  logic        r0_credit_ret;
  logic        r1_dout_valid;
  logic [31:0] r1_dout;
  logic        r1_credit_ret;
  logic        sram_addr_valid;
  logic        sram_ready;
  logic [17:0] sram_addr;
  logic [31:0] sram_data_in;
  logic [3:0]  sram_write_mask;
  logic [31:0] sram_data_out;
  logic        sram_data_out_valid;
  logic        proto_err;

  modport master (
    input  w0_valid, w0_req, w1_valid, w1_req,
    input  r0_valid, r0_addr, r1_valid, r1_addr,
    input  r0_credit_ret, r1_credit_ret,
    input  sram_ready, sram_data_out, sram_data_out_valid,
    output w0_pop, w1_pop, r0_pop, r1_pop,
    output r0_dout_valid, r0_dout, r1_dout_valid, r1_dout,
    output sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    output proto_err
  );

  modport slave (
    output w0_valid, w0_req, w1_valid, w1_req,
    output r0_valid, r0_addr, r1_valid, r1_addr,
    output r0_credit_ret, r1_credit_ret,
    output sram_ready, sram_data_out, sram_data_out_valid,
    input  w0_pop, w1_pop, r0_pop, r1_pop,
    input  r0_dout_valid, r0_dout, r1_dout_valid, r1_dout,
    input  sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    input  proto_err
  );
endinterface

// File: rtl/sram_rr_scheduler.sv
// Round-robin scheduler sharing one SRAM port among two write and two read requesters,
// with credit-gated reads and an in-order tag queue that steers returning read data.
module sram_rr_scheduler #(
  parameter int CREDITS   = 8,
  parameter int CW        = 4,
  parameter int TAG_DEPTH = 4
) (
  input logic                 sram_clock,
  input logic                 reset_n,
  sram_rr_scheduler_if.master bus
);
  typedef enum logic [1:0] {REQ_W0 = 2'd0, REQ_W1 = 2'd1, REQ_R0 = 2'd2, REQ_R1 = 2'd3} req_e;

  localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int TAG_CW = $clog2(TAG_DEPTH + 1);

  req_e                 r_rrPtr;
  req_e                 r_holdGrant;
  logic                 r_holdActive;
  logic [CW-1:0]        r_credit0;
  logic [CW-1:0]        r_credit1;
  logic [TAG_DEPTH-1:0] r_tagMem;
  logic [TAG_AW-1:0]    r_tagRd;
  logic [TAG_AW-1:0]    r_tagWr;
  logic [TAG_CW-1:0]    r_tagCount;
  logic                 r_r0DoutValid;
  logic                 r_r1DoutValid;
  logic [31:0]          r_rdData;
  logic                 r_protoErr;

  logic [3:0]  w_elig;
  logic        w_tagRoom;
  logic        w_anyElig;
  req_e        w_arbWinner;
  req_e        w_grant;
  logic        w_cmdValid;
  logic        w_accept;
  logic        w_isRead;
  logic        w_dec0;
  logic        w_dec1;
  logic        w_tagPush;
  logic        w_tagPop;
  logic        w_strayData;
  logic        w_maskZeroWrite;
  logic        w_credOvf0;
  logic        w_credOvf1;
  logic [17:0] w_cmdAddr;
  logic [31:0] w_cmdData;
  logic [3:0]  w_cmdMask;

  function automatic logic [TAG_AW-1:0] tagNext(input logic [TAG_AW-1:0] p);
    return (p == TAG_AW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_tagRoom = (r_tagCount < TAG_CW'(TAG_DEPTH));
  assign w_elig = {bus.r1_valid && (r_credit1 != '0) && w_tagRoom,
                   bus.r0_valid && (r_credit0 != '0) && w_tagRoom,
                   bus.w1_valid,
                   bus.w0_valid};

  // Scan from farthest to nearest so the requester closest after the pointer wins.
  always_comb begin
    w_arbWinner = r_rrPtr;
    w_anyElig   = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      if (w_elig[2'(int'(r_rrPtr) + i)]) begin
        w_arbWinner = req_e'(2'(int'(r_rrPtr) + i));
        w_anyElig   = 1'b1;
      end
    end
  end

  assign w_grant    = r_holdActive ? r_holdGrant : w_arbWinner;
  assign w_cmdValid = reset_n && (r_holdActive || w_anyElig);
  assign w_accept   = w_cmdValid && bus.sram_ready;
  assign w_isRead   = (w_grant == REQ_R0) || (w_grant == REQ_R1);

  always_comb begin
    w_cmdAddr = '0;
    w_cmdData = '0;
    w_cmdMask = '0;
    if (w_cmdValid) begin
      case (w_grant)
        REQ_W0: {w_cmdMask, w_cmdAddr, w_cmdData} = bus.w0_req;
        REQ_W1: {w_cmdMask, w_cmdAddr, w_cmdData} = bus.w1_req;
        REQ_R0: w_cmdAddr = bus.r0_addr;
        REQ_R1: w_cmdAddr = bus.r1_addr;
        default: w_cmdAddr = '0;
      endcase
    end
  end

  assign bus.sram_addr_valid = w_cmdValid;
  assign bus.sram_addr       = w_cmdAddr;
  assign bus.sram_data_in    = w_cmdData;
  assign bus.sram_write_mask = w_cmdMask;
  assign bus.w0_pop          = w_accept && (w_grant == REQ_W0);
  assign bus.w1_pop          = w_accept && (w_grant == REQ_W1);
  assign bus.r0_pop          = w_accept && (w_grant == REQ_R0);
  assign bus.r1_pop          = w_accept && (w_grant == REQ_R1);

  assign w_dec0          = w_accept && (w_grant == REQ_R0);
  assign w_dec1          = w_accept && (w_grant == REQ_R1);
  assign w_tagPush       = w_accept && w_isRead;
  assign w_tagPop        = bus.sram_data_out_valid && (r_tagCount != '0);
  assign w_strayData     = bus.sram_data_out_valid && (r_tagCount == '0);
  assign w_maskZeroWrite = w_accept && !w_isRead && (w_cmdMask == 4'b0000);
  assign w_credOvf0      = bus.r0_credit_ret && !w_dec0 && (r_credit0 == CW'(CREDITS));
  assign w_credOvf1      = bus.r1_credit_ret && !w_dec1 && (r_credit1 == CW'(CREDITS));

  // A stalled grant is frozen until the SRAM takes it; the pointer moves only on acceptance.
  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rrPtr      <= REQ_R1;
      r_holdGrant  <= REQ_W0;
      r_holdActive <= 1'b0;
    end else if (w_accept) begin
      r_rrPtr      <= w_grant;
      r_holdActive <= 1'b0;
    end else if (w_cmdValid) begin
      r_holdGrant  <= w_grant;
      r_holdActive <= 1'b1;
    end
  end

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_credit0 <= CW'(CREDITS);
      r_credit1 <= CW'(CREDITS);
    end else begin
      if (w_dec0 && !bus.r0_credit_ret) r_credit0 <= r_credit0 - 1'b1;
      else if (bus.r0_credit_ret && !w_dec0 && !w_credOvf0) r_credit0 <= r_credit0 + 1'b1;
      if (w_dec1 && !bus.r1_credit_ret) r_credit1 <= r_credit1 - 1'b1;
      else if (bus.r1_credit_ret && !w_dec1 && !w_credOvf1) r_credit1 <= r_credit1 + 1'b1;
    end
  end

  // Tag queue remembers which read port each outstanding read belongs to, in issue order.
  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tagMem   <= '0;
      r_tagRd    <= '0;
      r_tagWr    <= '0;
      r_tagCount <= '0;
    end else begin
      if (w_tagPush) begin
        r_tagMem[r_tagWr] <= (w_grant == REQ_R1);
        r_tagWr           <= tagNext(r_tagWr);
      end
      if (w_tagPop) r_tagRd <= tagNext(r_tagRd);
      if (w_tagPush && !w_tagPop) r_tagCount <= r_tagCount + 1'b1;
      else if (w_tagPop && !w_tagPush) r_tagCount <= r_tagCount - 1'b1;
    end
  end

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_r0DoutValid <= 1'b0;
      r_r1DoutValid <= 1'b0;
      r_rdData      <= '0;
      r_protoErr    <= 1'b0;
    end else begin
      r_r0DoutValid <= w_tagPop && !r_tagMem[r_tagRd];
      r_r1DoutValid <= w_tagPop && r_tagMem[r_tagRd];
      if (w_tagPop) r_rdData <= bus.sram_data_out;
      if (w_strayData || w_maskZeroWrite || w_credOvf0 || w_credOvf1) r_protoErr <= 1'b1;
    end
  end

  assign bus.r0_dout_valid = r_r0DoutValid;
  assign bus.r1_dout_valid = r_r1DoutValid;
  assign bus.r0_dout       = r_rdData;
  assign bus.r1_dout       = r_rdData;
  assign bus.proto_err     = r_protoErr;
endmodule
